sra_datapath_ctrl: RTL and testbench
====================================

Name: sra_datapath_ctrl

Overview:
- Moore FSM controller that sequences the signed-arithmetic-right-shift datapath for one operation per start/ack handshake.
- Drives every tri-state bus enable, register load (LR), ALU opcode and the Done/result strobe of the datapath.
- Latches the requester's mode and opcodes, then steps through load, AU1, shift and AU2 phases.
- Holds Done until the requester acknowledges or a timeout expires.

Parameters:
- ACK_TIMEOUT, 15: cycles S_DONE waits for ack before returning to S_IDLE. 0 = wait forever.
- CNT_W, 4: width of the timeout counter. Must satisfy 2^CNT_W > ACK_TIMEOUT.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in S_IDLE
- ack  in  1  requester has consumed Result; sampled only in S_DONE
- mode  in  2  latched at start. mode[0]: AU2 operand select (0=R4, 1=R5). mode[1]: 1 = do not write AU1 back into R1
- opcode_in  in  4  latched at start. [1:0] is the AU1 op, [3:2] is the AU2 op
- busy  out  1  high in every state except S_IDLE
- In  out  1  drives Input1/Input2 onto E/F
- AU1_Bus3  out  1  drives AU1 onto E
- AU1_Bus4  out  1  drives AU1 onto F; tied 0 in this revision
- Bus2  out  2  AU1 operand-B select (01=R1, 10=R2)
- Bus5  out  2  AU2 operand select (01=R4, 10=R5)
- Bus7  out  2  R3 source select (01=Sh3, 10=AU2)
- LR  out  5  register loads R1..R5, bit i loads R(i+1)
- Opcode  out  4  ALU opcodes: [1:0] to AU1, [3:2] to AU2
- Done  out  1  enables Result

Behaviour:
- All outputs are registered and decoded from the next state, so each state's control word is valid for the whole cycle that state occupies.
- Reset (rst_n low, asynchronous, including mid-operation):
  - state = S_IDLE; mode/opcode latches = 0; timeout counter = 0.
  - Every output = 0: all buses high-Z, no loads, Done=0, busy=0.
- In every state, any output not listed for that state is 0.
- Opcode carries the latched opcode from S_LOAD through S_AU2_WB, and is 0 in S_IDLE and S_DONE.
- Per-state control words:
  - S_IDLE: if start=1, latch mode/opcode_in and go to S_LOAD.
  - S_LOAD: In=1, LR=00011 (R1<=Input1, R2<=Input2). Go to S_AU1.
  - S_AU1: Bus2=10, Opcode[1:0]=op1. AU1 registers its result at the end of this cycle. Go to S_AU1_WB.
  - S_AU1_WB: Bus2=10, Opcode[1:0]=op1, LR[3]=1 (R4<=AU1). If mode[1]=0, also AU1_Bus3=1 and LR[0]=1 (R1<=AU1). Go to S_SHIFT.
  - S_SHIFT: LR[4]=1 (R5<=R1>>>1), Bus7=01, LR[2]=1 (R3<=R1>>>2). Go to S_AU2.
  - S_AU2: Opcode[3:2]=op2. Bus5=01 if mode[0]=0, else 10. Go to S_AU2_WB.
  - S_AU2_WB: Bus5 and Opcode held as in S_AU2, Bus7=10, LR[2]=1 (R3<=AU2). Go to S_DONE.
  - S_DONE: Done=1, busy=1, counter increments each cycle.
    - ack=1: go to S_IDLE.
    - ACK_TIMEOUT != 0 and counter reaches ACK_TIMEOUT-1 with no ack: go to S_IDLE.
    - Counter clears on exit.
- Latency: start sampled at edge N → S_LOAD during cycle N+1 → Done first high in cycle N+7.
- Bus-exclusion invariants; each one is an assertion:
  - In and AU1_Bus3 never both 1.
  - Bus2, Bus5 and Bus7 are each one-hot or zero, never 11.
  - LR[2] is high only while Bus7 is non-zero.
- start while busy=1 is ignored and not queued.
- start and ack both high in S_DONE: return to S_IDLE. start is not accepted that cycle; the requester re-asserts it.
- opcode_in/mode changes after the start edge have no effect until the next operation.

Decomposition:
- Package sra_ctrl_pkg holds:
  - state enum: S_IDLE, S_LOAD, S_AU1, S_AU1_WB, S_SHIFT, S_AU2, S_AU2_WB, S_DONE; 3-bit binary encoding.
  - bus-select constants: SEL_NONE=2'b00, SEL_A=2'b01, SEL_B=2'b10.
  - LR bit indices.
- One natural sub-module: sra_ctrl_decode. It is combinational (next state + latched mode/opcode → control word); the top registers its outputs.

Test Plan:
- Reset mid-operation: assert rst_n=0 in S_SHIFT → all outputs 0 immediately, without waiting for clk; after release, busy=0 and a new start is accepted.
- Basic sequence: mode=00, opcode_in=4'b0110, start for 1 cycle → per-cycle control words:
  - LR: 00011, 00000, 01001, 10100, 00000, 00100.
  - Opcode[1:0]=10 in cycles 2–3; Opcode[3:2]=01 in cycles 5–6.
  - Done=1 in cycle 7.
- mode=11 → in S_AU1_WB, AU1_Bus3=0 and LR=01000; in S_AU2 and S_AU2_WB, Bus5=10.
- Handshake:
  - ack in cycle 3 of S_DONE → busy falls next edge.
  - start pulsed while busy → ignored; only one Done episode occurs.
- Timeout: ACK_TIMEOUT=15, ack never asserted → Done high exactly 15 cycles, then S_IDLE. With ACK_TIMEOUT=0 → Done stays high for 100+ cycles.
- Random start/ack/mode over 10k cycles:
  - no bus-exclusion assertion fires;
  - every accepted start yields exactly one Done rising edge, 7 cycles later.

Source files
------------

// File: rtl/sra_ctrl_pkg.sv
// Shared types and constants for the signed-shift datapath controller.
// Pure declarations: no logic, no latency, no flow control.
package sra_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_AU1    = 3'd2,
    S_AU1_WB = 3'd3,
    S_SHIFT  = 3'd4,
    S_AU2    = 3'd5,
    S_AU2_WB = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_A    = 2'b01;
  localparam logic [1:0] SEL_B    = 2'b10;

  localparam int LR_R1 = 0;
  localparam int LR_R2 = 1;
  localparam int LR_R3 = 2;
  localparam int LR_R4 = 3;
  localparam int LR_R5 = 4;

  typedef struct packed {
    logic       busy;
    logic       in_en;
    logic       au1_bus3;
    logic       au1_bus4;
    logic [1:0] bus2;
    logic [1:0] bus5;
    logic [1:0] bus7;
    logic [4:0] lr;
    logic [3:0] opcode;
    logic       done;
  } ctrl_t;

endpackage

// File: rtl/sra_ctrl_decode.sv
// Combinational state -> datapath control word decode; zero latency, no flow control.
// Fed with the next state so the parent can register the word in lockstep with the state.
module sra_ctrl_decode
  import sra_ctrl_pkg::*;
(
  input  logic [2:0] i_state,
  input  logic [1:0] i_mode,
  input  logic [3:0] i_opcode,
  output logic       o_busy,
  output logic       o_in,
  output logic       o_au1_bus3,
  output logic       o_au1_bus4,
  output logic [1:0] o_bus2,
  output logic [1:0] o_bus5,
  output logic [1:0] o_bus7,
  output logic [4:0] o_lr,
  output logic [3:0] o_opcode,
  output logic       o_done
);

  state_t w_state;
  assign w_state = state_t'(i_state);

  always_comb begin
    o_busy     = (w_state != S_IDLE);
    o_in       = 1'b0;
    o_au1_bus3 = 1'b0;
    o_au1_bus4 = 1'b0;
    o_bus2     = SEL_NONE;
    o_bus5     = SEL_NONE;
    o_bus7     = SEL_NONE;
    o_lr       = '0;
    o_opcode   = '0;
    o_done     = 1'b0;
    case (w_state)
      S_LOAD: begin
        o_in        = 1'b1;
        o_lr[LR_R1] = 1'b1;
        o_lr[LR_R2] = 1'b1;
      end
      S_AU1: begin
        o_bus2        = SEL_B;
        o_opcode[1:0] = i_opcode[1:0];
      end
      S_AU1_WB: begin
        o_bus2        = SEL_B;
        o_opcode[1:0] = i_opcode[1:0];
        o_lr[LR_R4]   = 1'b1;
        // mode[1] keeps R1 holding Input1 so the shift works on the raw operand
        if (!i_mode[1]) begin
          o_au1_bus3  = 1'b1;
          o_lr[LR_R1] = 1'b1;
        end
      end
      S_SHIFT: begin
        o_lr[LR_R5] = 1'b1;
        o_bus7      = SEL_A;
        o_lr[LR_R3] = 1'b1;
      end
      S_AU2: begin
        o_opcode[3:2] = i_opcode[3:2];
        o_bus5        = i_mode[0] ? SEL_B : SEL_A;
      end
      S_AU2_WB: begin
        o_opcode[3:2] = i_opcode[3:2];
        o_bus5        = i_mode[0] ? SEL_B : SEL_A;
        o_bus7        = SEL_B;
        o_lr[LR_R3]   = 1'b1;
      end
      S_DONE: o_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/sra_datapath_ctrl.sv
// Moore sequencer for the signed arithmetic-right-shift datapath: start -> Done in 7 cycles.
// Starts are ignored while busy; Done holds until ack or the ack timeout expires.
module sra_datapath_ctrl #(
  parameter int ACK_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       ack,
  input  logic [1:0] mode,
  input  logic [3:0] opcode_in,
  output logic       busy,
  output logic       In,
  output logic       AU1_Bus3,
  output logic       AU1_Bus4,
  output logic [1:0] Bus2,
  output logic [1:0] Bus5,
  output logic [1:0] Bus7,
  output logic [4:0] LR,
  output logic [3:0] Opcode,
  output logic       Done
);
  import sra_ctrl_pkg::*;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_mode, w_mode_nxt;
  logic [3:0]       r_op, w_op_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  ctrl_t            r_ctrl, w_ctrl_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mode  <= '0;
      r_op    <= '0;
      r_cnt   <= '0;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_op    <= w_op_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ctrl  <= w_ctrl_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_op_nxt    = r_op;
    w_cnt_nxt   = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_LOAD;
          w_mode_nxt  = mode;
          w_op_nxt    = opcode_in;
        end
      end
      S_LOAD:   w_state_nxt = S_AU1;
      S_AU1:    w_state_nxt = S_AU1_WB;
      S_AU1_WB: w_state_nxt = S_SHIFT;
      S_SHIFT:  w_state_nxt = S_AU2;
      S_AU2:    w_state_nxt = S_AU2_WB;
      S_AU2_WB: w_state_nxt = S_DONE;
      S_DONE: begin
        // a zero timeout lets the counter free-run while Done waits on ack
        if (ack || ((ACK_TIMEOUT != 0) && (r_cnt == LP_LAST))) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // decoding the next state keeps each control word aligned with its state cycle
  sra_ctrl_decode u_decode (
    .i_state    (w_state_nxt),
    .i_mode     (w_mode_nxt),
    .i_opcode   (w_op_nxt),
    .o_busy     (w_ctrl_nxt.busy),
    .o_in       (w_ctrl_nxt.in_en),
    .o_au1_bus3 (w_ctrl_nxt.au1_bus3),
    .o_au1_bus4 (w_ctrl_nxt.au1_bus4),
    .o_bus2     (w_ctrl_nxt.bus2),
    .o_bus5     (w_ctrl_nxt.bus5),
    .o_bus7     (w_ctrl_nxt.bus7),
    .o_lr       (w_ctrl_nxt.lr),
    .o_opcode   (w_ctrl_nxt.opcode),
    .o_done     (w_ctrl_nxt.done)
  );

  assign busy     = r_ctrl.busy;
  assign In       = r_ctrl.in_en;
  assign AU1_Bus3 = r_ctrl.au1_bus3;
  assign AU1_Bus4 = r_ctrl.au1_bus4;
  assign Bus2     = r_ctrl.bus2;
  assign Bus5     = r_ctrl.bus5;
  assign Bus7     = r_ctrl.bus7;
  assign LR       = r_ctrl.lr;
  assign Opcode   = r_ctrl.opcode;
  assign Done     = r_ctrl.done;

  a_bus_e_excl: assert property (@(posedge clk) disable iff (!rst_n) !(In && AU1_Bus3));
  a_bus2_sel:   assert property (@(posedge clk) disable iff (!rst_n) Bus2 != 2'b11);
  a_bus5_sel:   assert property (@(posedge clk) disable iff (!rst_n) Bus5 != 2'b11);
  a_bus7_sel:   assert property (@(posedge clk) disable iff (!rst_n) Bus7 != 2'b11);
  a_r3_src:     assert property (@(posedge clk) disable iff (!rst_n) LR[LR_R3] |-> (Bus7 != SEL_NONE));

endmodule

// File: tb/tb_sra_datapath_ctrl.sv
// Scoreboard bench for sra_datapath_ctrl: expected control words are queued at start
// and popped every cycle; a second instance covers the wait-forever ack mode.
module tb_sra_datapath_ctrl;

  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, ack = 1'b0, start0 = 1'b0, ack0 = 1'b0;
  logic [1:0] mode = '0;
  logic [3:0] opcode_in = '0;

  logic       busy, In, AU1_Bus3, AU1_Bus4, Done;
  logic [1:0] Bus2, Bus5, Bus7;
  logic [4:0] LR;
  logic [3:0] Opcode;

  logic       z_busy, z_In, z_AU1_Bus3, z_AU1_Bus4, z_Done;
  logic [1:0] z_Bus2, z_Bus5, z_Bus7;
  logic [4:0] z_LR;
  logic [3:0] z_Opcode;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       busy;
    logic       in_;
    logic       b3;
    logic       b4;
    logic [1:0] b2;
    logic [1:0] b5;
    logic [1:0] b7;
    logic [4:0] lr;
    logic [3:0] op;
    logic       done;
  } cw_t;

  typedef struct packed {
    cw_t        cw;
    logic [3:0] opm;
  } exp_t;

  exp_t sb[$];
  int   done_q[$];

  always #5 clk = ~clk;

  sra_datapath_ctrl #(.ACK_TIMEOUT(TMO), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ack(ack), .mode(mode), .opcode_in(opcode_in),
    .busy(busy), .In(In), .AU1_Bus3(AU1_Bus3), .AU1_Bus4(AU1_Bus4), .Bus2(Bus2), .Bus5(Bus5),
    .Bus7(Bus7), .LR(LR), .Opcode(Opcode), .Done(Done)
  );

  sra_datapath_ctrl #(.ACK_TIMEOUT(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .ack(ack0), .mode(mode), .opcode_in(opcode_in),
    .busy(z_busy), .In(z_In), .AU1_Bus3(z_AU1_Bus3), .AU1_Bus4(z_AU1_Bus4), .Bus2(z_Bus2),
    .Bus5(z_Bus5), .Bus7(z_Bus7), .LR(z_LR), .Opcode(z_Opcode), .Done(z_Done)
  );

  // Phase 0 = idle, 1..6 = LOAD..AU2_WB, 7 = DONE. Opcode bits whose value in a
  // phase is not pinned down are masked out of the comparison.
  function automatic exp_t exp_word(int ph, logic [1:0] md, logic [3:0] op);
    exp_t e;
    e = '0;
    e.opm = 4'hF;
    e.cw.busy = (ph != 0);
    case (ph)
      1: begin e.cw.in_ = 1'b1; e.cw.lr = 5'b00011; e.opm = 4'b0000; end
      2: begin e.cw.b2 = 2'b10; e.cw.op = {2'b00, op[1:0]}; e.opm = 4'b0011; end
      3: begin
        e.cw.b2 = 2'b10; e.cw.op = {2'b00, op[1:0]}; e.opm = 4'b0011;
        e.cw.lr = md[1] ? 5'b01000 : 5'b01001;
        e.cw.b3 = !md[1];
      end
      4: begin e.cw.lr = 5'b10100; e.cw.b7 = 2'b01; e.opm = 4'b0000; end
      5: begin
        e.cw.b5 = md[0] ? 2'b10 : 2'b01; e.cw.op = {op[3:2], 2'b00}; e.opm = 4'b1100;
      end
      6: begin
        e.cw.b5 = md[0] ? 2'b10 : 2'b01; e.cw.op = {op[3:2], 2'b00}; e.opm = 4'b1100;
        e.cw.b7 = 2'b10; e.cw.lr = 5'b00100;
      end
      7: e.cw.done = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  function automatic cw_t obs_word();
    cw_t o;
    o.busy = busy; o.in_ = In; o.b3 = AU1_Bus3; o.b4 = AU1_Bus4;
    o.b2 = Bus2; o.b5 = Bus5; o.b7 = Bus7; o.lr = LR; o.op = Opcode; o.done = Done;
    return o;
  endfunction

  // Stimulus-side helper: queue the expected per-cycle words of one operation
  // with nd Done cycles, followed by three idle cycles.
  task automatic push_op(logic [1:0] md, logic [3:0] op, int nd);
    for (int p = 1; p <= 6; p++) sb.push_back(exp_word(p, md, op));
    for (int k = 0; k < nd; k++) sb.push_back(exp_word(7, md, op));
    for (int k = 0; k < 3; k++) sb.push_back(exp_word(0, md, op));
  endtask

  task automatic test_reset();
    cw_t o;
    #1;
    o = obs_word();
    n_checks++;
    if (o !== cw_t'(0)) begin
      n_fail++; $display("FAIL reset_state got %h expected %h", o, cw_t'(0));
    end
    n_checks++;
    if ({z_busy, z_Done, z_LR} !== 7'd0) begin
      n_fail++; $display("FAIL reset_state_dut0 got %b expected 0", {z_busy, z_Done, z_LR});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    o = obs_word();
    n_checks++;
    if (o !== cw_t'(0)) begin
      n_fail++; $display("FAIL idle_after_reset got %h expected %h", o, cw_t'(0));
    end
  endtask

  task automatic test_basic();
    cw_t o; exp_t e;
    push_op(2'b00, 4'b0110, 2);
    @(negedge clk); mode = 2'b00; opcode_in = 4'b0110; start = 1'b1;
    for (int c = 1; c <= 2 + 9; c++) begin
      @(negedge clk);
      start = 1'b0; ack = (c == 6 + 2);
      mode = 2'($urandom_range(0, 3)); opcode_in = 4'($urandom_range(0, 15));
      o = obs_word(); e = sb.pop_front(); o.op = o.op & e.opm;
      n_checks++;
      if (o !== e.cw) begin
        n_fail++; $display("FAIL basic cycle %0d got %h expected %h", c, o, e.cw);
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_mode11();
    cw_t o; exp_t e;
    push_op(2'b11, 4'b1001, 1);
    @(negedge clk); mode = 2'b11; opcode_in = 4'b1001; start = 1'b1;
    for (int c = 1; c <= 1 + 9; c++) begin
      @(negedge clk);
      start = 1'b0; ack = (c == 6 + 1); mode = 2'b00; opcode_in = 4'b0000;
      o = obs_word(); e = sb.pop_front(); o.op = o.op & e.opm;
      n_checks++;
      if (o !== e.cw) begin
        n_fail++; $display("FAIL mode11 cycle %0d got %h expected %h", c, o, e.cw);
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_handshake();
    cw_t o; exp_t e;
    push_op(2'b01, 4'b1110, 3);
    @(negedge clk); mode = 2'b01; opcode_in = 4'b1110; start = 1'b1;
    for (int c = 1; c <= 3 + 9; c++) begin
      @(negedge clk);
      start = (c == 3) || (c == 8); ack = (c == 6 + 3);
      o = obs_word(); e = sb.pop_front(); o.op = o.op & e.opm;
      n_checks++;
      if (o !== e.cw) begin
        n_fail++; $display("FAIL handshake cycle %0d got %h expected %h", c, o, e.cw);
      end
    end
    ack = 1'b0; start = 1'b0;
  endtask

  task automatic test_timeout();
    cw_t o; exp_t e;
    push_op(2'b10, 4'b0111, TMO);
    @(negedge clk); mode = 2'b10; opcode_in = 4'b0111; start = 1'b1;
    for (int c = 1; c <= TMO + 9; c++) begin
      @(negedge clk);
      start = 1'b0; ack = 1'b0;
      o = obs_word(); e = sb.pop_front(); o.op = o.op & e.opm;
      n_checks++;
      if (o !== e.cw) begin
        n_fail++; $display("FAIL timeout cycle %0d got %h expected %h", c, o, e.cw);
      end
    end
  endtask

  task automatic test_no_timeout();
    int hi;
    hi = 0;
    @(negedge clk); start0 = 1'b1;
    for (int c = 1; c <= 130; c++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (z_Done) hi++;
    end
    n_checks++;
    if (hi !== 124 || z_busy !== 1'b1) begin
      n_fail++; $display("FAIL no_timeout done_cycles %0d busy %b expected 124 and 1", hi, z_busy);
    end
    ack0 = 1'b1;
    @(negedge clk); ack0 = 1'b0;
    n_checks++;
    if ({z_busy, z_Done} !== 2'b00) begin
      n_fail++; $display("FAIL no_timeout_release got %b expected 00", {z_busy, z_Done});
    end
  endtask

  task automatic test_reset_mid();
    cw_t o;
    @(negedge clk); mode = 2'b00; opcode_in = 4'b0101; start = 1'b1;
    for (int c = 1; c <= 4; c++) begin @(negedge clk); start = 1'b0; end
    n_checks++;
    if ({busy, LR, Bus7} !== {1'b1, 5'b10100, 2'b01}) begin
      n_fail++; $display("FAIL pre_reset_shift got %b expected 1_10100_01", {busy, LR, Bus7});
    end
    rst_n = 1'b0;
    #1;
    o = obs_word();
    n_checks++;
    if (o !== cw_t'(0)) begin
      n_fail++; $display("FAIL async_reset got %h expected %h", o, cw_t'(0));
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_busy got %b expected 0", busy);
    end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_checks++;
    if ({busy, In, LR} !== {1'b1, 1'b1, 5'b00011}) begin
      n_fail++; $display("FAIL post_reset_start got %b expected 1_1_00011", {busy, In, LR});
    end
    repeat (6) @(negedge clk);
    ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    n_checks++;
    if ({busy, Done} !== 2'b00) begin
      n_fail++; $display("FAIL post_reset_ack got %b expected 00", {busy, Done});
    end
  endtask

  task automatic test_random();
    int ph, cnt, t;
    logic [1:0] md_l;
    logic [3:0] op_l;
    logic prev_done;
    cw_t o; exp_t e;
    ph = 0; cnt = 0; md_l = '0; op_l = '0; prev_done = 1'b0;
    for (int k = 0; k < 10000; k++) begin
      @(negedge clk);
      o = obs_word(); e = exp_word(ph, md_l, op_l); o.op = o.op & e.opm;
      n_checks++;
      if (o !== e.cw) begin
        n_fail++; $display("FAIL random_word cycle %0d got %h expected %h", k, o, e.cw);
      end
      if (Done && !prev_done) begin
        n_checks++;
        if (done_q.size() == 0) begin
          n_fail++; $display("FAIL random_done_edge cycle %0d got unexpected Done expected none", k);
        end else begin
          t = done_q.pop_front();
          if (t !== k) begin
            n_fail++; $display("FAIL random_done_edge got cycle %0d expected cycle %0d", k, t);
          end
        end
      end
      prev_done = Done;
      start = (k < 9960) && ($urandom_range(0, 2) == 0);
      ack = ($urandom_range(0, 4) == 0);
      mode = 2'($urandom_range(0, 3));
      opcode_in = 4'($urandom_range(0, 15));
      case (ph)
        0: if (start) begin ph = 1; md_l = mode; op_l = opcode_in; done_q.push_back(k + 7); end
        7: begin
          if (ack || cnt == TMO - 1) begin ph = 0; cnt = 0; end
          else cnt++;
        end
        default: ph++;
      endcase
    end
    start = 1'b0; ack = 1'b0;
    n_checks++;
    if (done_q.size() !== 0) begin
      n_fail++; $display("FAIL random_pending got %0d outstanding expected 0", done_q.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_mode11();
    test_handshake();
    test_timeout();
    test_no_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
